rrf_alloc: RTL and testbench

RRF_ALLOC -- requirements
Module: rrf_alloc

---
 rtl/rrf_alloc_if.sv | 66 ++++++
 rtl/rrf_alloc.sv | 128 ++++++++++++
 tb/tb_rrf_alloc.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rrf_alloc_if.sv
// Rename-register-file allocator bundle: allocate/retire control, write-back, operand and commit read ports.
// The slave modport is the allocator's view; the master modport is the dispatch/ROB/execute side.
interface rrf_alloc_if #(
  parameter int RRF_SEL  = 6,
  parameter int DATA_LEN = 32
);
  logic [1:0]          req_num_i;
  logic                prmiss_i;
  logic [1:0]          comnum_i;
  logic                alloc_ok_o;
  logic [RRF_SEL-1:0]  dp1_addr_o;
  logic [RRF_SEL-1:0]  dp2_addr_o;
  logic [RRF_SEL-1:0]  dispatch_ptr_o;
  logic [RRF_SEL-1:0]  commit_ptr_o;
  logic [RRF_SEL:0]    rrf_freenum_o;

  logic                wb1_en_i;
  logic [RRF_SEL-1:0]  wb1_addr_i;
  logic [DATA_LEN-1:0] wb1_data_i;
  logic                wb2_en_i;
  logic [RRF_SEL-1:0]  wb2_addr_i;
  logic [DATA_LEN-1:0] wb2_data_i;
  logic                wb3_en_i;
  logic [RRF_SEL-1:0]  wb3_addr_i;
  logic [DATA_LEN-1:0] wb3_data_i;

  logic [RRF_SEL-1:0]  rd1_addr_i;
  logic [RRF_SEL-1:0]  rd2_addr_i;
  logic [RRF_SEL-1:0]  rd3_addr_i;
  logic [RRF_SEL-1:0]  rd4_addr_i;
  logic [DATA_LEN-1:0] rd1_data_o;
  logic [DATA_LEN-1:0] rd2_data_o;
  logic [DATA_LEN-1:0] rd3_data_o;
  logic [DATA_LEN-1:0] rd4_data_o;
  logic                rd1_valid_o;
  logic                rd2_valid_o;
  logic                rd3_valid_o;
  logic                rd4_valid_o;

  logic [DATA_LEN-1:0] com1_data_o;
  logic [DATA_LEN-1:0] com2_data_o;

  modport master (
    output req_num_i, prmiss_i, comnum_i,
    output wb1_en_i, wb1_addr_i, wb1_data_i,
    output wb2_en_i, wb2_addr_i, wb2_data_i,
    output wb3_en_i, wb3_addr_i, wb3_data_i,
    output rd1_addr_i, rd2_addr_i, rd3_addr_i, rd4_addr_i,
    input  alloc_ok_o, dp1_addr_o, dp2_addr_o, dispatch_ptr_o, commit_ptr_o, rrf_freenum_o,
    input  rd1_data_o, rd2_data_o, rd3_data_o, rd4_data_o,
    input  rd1_valid_o, rd2_valid_o, rd3_valid_o, rd4_valid_o,
    input  com1_data_o, com2_data_o
  );

  modport slave (
    input  req_num_i, prmiss_i, comnum_i,
    input  wb1_en_i, wb1_addr_i, wb1_data_i,
    input  wb2_en_i, wb2_addr_i, wb2_data_i,
    input  wb3_en_i, wb3_addr_i, wb3_data_i,
    input  rd1_addr_i, rd2_addr_i, rd3_addr_i, rd4_addr_i,
    output alloc_ok_o, dp1_addr_o, dp2_addr_o, dispatch_ptr_o, commit_ptr_o, rrf_freenum_o,
    output rd1_data_o, rd2_data_o, rd3_data_o, rd4_data_o,
    output rd1_valid_o, rd2_valid_o, rd3_valid_o, rd4_valid_o,
    output com1_data_o, com2_data_o
  );
endinterface

// File: rtl/rrf_alloc.sv
// Rename register file: circular tag allocator with valid-tracked data array, 3 write-back and 4 bypassing read ports.
// Grant and reads are combinational; pointer/count/valid/data updates land at the next clock edge.
module rrf_alloc #(
  parameter int RRF_NUM  = 64,
  parameter int RRF_SEL  = 6,
  parameter int DATA_LEN = 32
) (
  input logic        clk,
  input logic        reset,
  rrf_alloc_if.slave bus
);
  localparam logic [RRF_SEL:0]   FREE_ALL = (RRF_SEL+1)'(RRF_NUM);
  localparam logic [RRF_SEL-1:0] ONE      = RRF_SEL'(1);

  logic [RRF_SEL-1:0]  dispatch_q, dispatch_d;
  logic [RRF_SEL-1:0]  commit_q, commit_d;
  logic [RRF_SEL:0]    freenum_q, freenum_d;
  logic [RRF_NUM-1:0]  valid_q, valid_d;
  logic [DATA_LEN-1:0] data_q [RRF_NUM];

  logic                alloc_ok;
  logic [RRF_SEL:0]    req_ext, com_ext, alloc_n;
  logic [RRF_SEL-1:0]  dp2_addr;

  logic                wb_en   [3];
  logic [RRF_SEL-1:0]  wb_addr [3];
  logic [DATA_LEN-1:0] wb_data [3];
  logic [RRF_SEL-1:0]  rd_addr [4];
  logic [DATA_LEN-1:0] rd_data [4];
  logic                rd_valid[4];

  assign wb_en[0]   = bus.wb1_en_i;
  assign wb_en[1]   = bus.wb2_en_i;
  assign wb_en[2]   = bus.wb3_en_i;
  assign wb_addr[0] = bus.wb1_addr_i;
  assign wb_addr[1] = bus.wb2_addr_i;
  assign wb_addr[2] = bus.wb3_addr_i;
  assign wb_data[0] = bus.wb1_data_i;
  assign wb_data[1] = bus.wb2_data_i;
  assign wb_data[2] = bus.wb3_data_i;
  assign rd_addr[0] = bus.rd1_addr_i;
  assign rd_addr[1] = bus.rd2_addr_i;
  assign rd_addr[2] = bus.rd3_addr_i;
  assign rd_addr[3] = bus.rd4_addr_i;

  assign req_ext  = {{(RRF_SEL-1){1'b0}}, bus.req_num_i};
  assign com_ext  = {{(RRF_SEL-1){1'b0}}, bus.comnum_i};
  assign dp2_addr = dispatch_q + ONE;

  assign alloc_ok = !reset && !bus.prmiss_i && (bus.req_num_i != 2'd0) && (freenum_q >= req_ext);
  assign alloc_n  = alloc_ok ? req_ext : '0;

  always_comb begin
    commit_d   = commit_q + com_ext[RRF_SEL-1:0];
    dispatch_d = dispatch_q + alloc_n[RRF_SEL-1:0];
    freenum_d  = freenum_q - alloc_n + com_ext;
    // A flush discards everything younger than the retiring entries
    if (bus.prmiss_i) begin
      dispatch_d = commit_d;
      freenum_d  = FREE_ALL;
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < 3; k++) begin
      if (wb_en[k]) valid_d[wb_addr[k]] = 1'b1;
    end
    // Freshly allocated tags must read not-ready even if a stale write-back targets them
    if (alloc_ok) begin
      valid_d[dispatch_q] = 1'b0;
      if (bus.req_num_i == 2'd2) valid_d[dp2_addr] = 1'b0;
    end
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      rd_data[j]  = data_q[rd_addr[j]];
      rd_valid[j] = valid_q[rd_addr[j]];
      for (int k = 0; k < 3; k++) begin
        if (wb_en[k] && (wb_addr[k] == rd_addr[j])) begin
          rd_data[j]  = wb_data[k];
          rd_valid[j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dispatch_q <= '0;
      commit_q   <= '0;
      freenum_q  <= FREE_ALL;
      valid_q    <= '0;
    end else begin
      dispatch_q <= dispatch_d;
      commit_q   <= commit_d;
      freenum_q  <= freenum_d;
      valid_q    <= valid_d;
    end
  end

  // Later ports overwrite earlier ones on an address collision
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        if (wb_en[k]) data_q[wb_addr[k]] <= wb_data[k];
      end
    end
  end

  assign bus.alloc_ok_o     = alloc_ok;
  assign bus.dp1_addr_o     = dispatch_q;
  assign bus.dp2_addr_o     = dp2_addr;
  assign bus.dispatch_ptr_o = dispatch_q;
  assign bus.commit_ptr_o   = commit_q;
  assign bus.rrf_freenum_o  = freenum_q;
  assign bus.rd1_data_o     = rd_data[0];
  assign bus.rd2_data_o     = rd_data[1];
  assign bus.rd3_data_o     = rd_data[2];
  assign bus.rd4_data_o     = rd_data[3];
  assign bus.rd1_valid_o    = rd_valid[0];
  assign bus.rd2_valid_o    = rd_valid[1];
  assign bus.rd3_valid_o    = rd_valid[2];
  assign bus.rd4_valid_o    = rd_valid[3];
  assign bus.com1_data_o    = data_q[commit_q];
  assign bus.com2_data_o    = data_q[commit_q + ONE];
endmodule

// File: tb/tb_rrf_alloc.sv
// Bench for rrf_alloc: directed scenarios plus a random phase, with a queue scoreboard for post-edge state.
module tb_rrf_alloc;
  localparam int N = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rrf_alloc_if #(.RRF_SEL(6), .DATA_LEN(32)) bus();
  rrf_alloc #(.RRF_NUM(64), .RRF_SEL(6), .DATA_LEN(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int          m_disp = 0, m_com = 0, m_free = N;
  bit          m_valid[N];
  logic [31:0] m_data [N];

  typedef struct { int disp; int com; int free; } exp_t;
  exp_t sb[$];

  bit          g_wb_en  [3];
  logic [5:0]  g_wb_addr[3];
  logic [31:0] g_wb_data[3];
  logic [5:0]  g_rd_addr[4];

  logic        obs_ok;
  logic [31:0] obs_rd_data [4];
  logic        obs_rd_valid[4];
  logic [31:0] obs_com1, obs_com2;

  always @(posedge clk) begin
    if (reset === 1'b0) begin
      assert (bus.req_num_i != 2'd3) else $error("illegal req_num_i=3");
      assert (int'(bus.comnum_i) <= N - int'(bus.rrf_freenum_o))
        else $error("comnum_i=%0d exceeds occupied count", bus.comnum_i);
    end
  end

  task automatic step(input bit rst, input int req, input int com, input bit pm);
    bit   ok;
    exp_t e;
    @(negedge clk);
    reset           = rst;
    bus.req_num_i   = 2'(req);
    bus.comnum_i    = 2'(com);
    bus.prmiss_i    = pm;
    bus.wb1_en_i    = g_wb_en[0];  bus.wb1_addr_i = g_wb_addr[0];  bus.wb1_data_i = g_wb_data[0];
    bus.wb2_en_i    = g_wb_en[1];  bus.wb2_addr_i = g_wb_addr[1];  bus.wb2_data_i = g_wb_data[1];
    bus.wb3_en_i    = g_wb_en[2];  bus.wb3_addr_i = g_wb_addr[2];  bus.wb3_data_i = g_wb_data[2];
    bus.rd1_addr_i  = g_rd_addr[0];
    bus.rd2_addr_i  = g_rd_addr[1];
    bus.rd3_addr_i  = g_rd_addr[2];
    bus.rd4_addr_i  = g_rd_addr[3];
    #1;
    ok = !rst && !pm && (req != 0) && (m_free >= req);
    obs_ok          = bus.alloc_ok_o;
    obs_rd_data[0]  = bus.rd1_data_o;   obs_rd_valid[0] = bus.rd1_valid_o;
    obs_rd_data[1]  = bus.rd2_data_o;   obs_rd_valid[1] = bus.rd2_valid_o;
    obs_rd_data[2]  = bus.rd3_data_o;   obs_rd_valid[2] = bus.rd3_valid_o;
    obs_rd_data[3]  = bus.rd4_data_o;   obs_rd_valid[3] = bus.rd4_valid_o;
    obs_com1        = bus.com1_data_o;
    obs_com2        = bus.com2_data_o;
    total++;
    if (bus.alloc_ok_o !== ok) begin
      bad++; $display("FAIL alloc_ok got=%b want=%b", bus.alloc_ok_o, ok);
    end
    if (!rst) begin
      total++;
      if (bus.dp1_addr_o !== 6'(m_disp)) begin
        bad++; $display("FAIL dp1_addr got=%0d want=%0d", bus.dp1_addr_o, m_disp);
      end
      total++;
      if (bus.dp2_addr_o !== 6'((m_disp + 1) % N)) begin
        bad++; $display("FAIL dp2_addr got=%0d want=%0d", bus.dp2_addr_o, (m_disp + 1) % N);
      end
    end
    if (rst) begin
      m_disp = 0; m_com = 0; m_free = N;
      foreach (m_valid[i]) m_valid[i] = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (g_wb_en[k]) begin
          m_data[g_wb_addr[k]]  = g_wb_data[k];
          m_valid[g_wb_addr[k]] = 1'b1;
        end
      end
      m_com = (m_com + com) % N;
      if (pm) begin
        m_disp = m_com;
        m_free = N;
      end else begin
        if (ok) begin
          for (int i = 0; i < req; i++) m_valid[(m_disp + i) % N] = 1'b0;
          m_disp = (m_disp + req) % N;
          m_free = m_free - req;
        end
        m_free = m_free + com;
      end
    end
    e.disp = m_disp; e.com = m_com; e.free = m_free;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    total++;
    if (bus.dispatch_ptr_o !== 6'(e.disp)) begin
      bad++; $display("FAIL dispatch_ptr got=%0d want=%0d", bus.dispatch_ptr_o, e.disp);
    end
    total++;
    if (bus.commit_ptr_o !== 6'(e.com)) begin
      bad++; $display("FAIL commit_ptr got=%0d want=%0d", bus.commit_ptr_o, e.com);
    end
    total++;
    if (bus.rrf_freenum_o !== 7'(e.free)) begin
      bad++; $display("FAIL freenum got=%0d want=%0d", bus.rrf_freenum_o, e.free);
    end
    g_wb_en = '{default: 1'b0};
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 2, 0, 0);
    total++;
    if (obs_ok !== 1'b0) begin bad++; $display("FAIL reset_alloc_ok got=%b want=0", obs_ok); end
    total++;
    if (bus.rrf_freenum_o !== 7'd64) begin
      bad++; $display("FAIL reset_freenum got=%0d want=64", bus.rrf_freenum_o);
    end
    g_rd_addr = '{6'd0, 6'd1, 6'd2, 6'd3};
    step(0, 0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      total++;
      if (obs_rd_valid[j] !== 1'b0) begin
        bad++; $display("FAIL reset_rd_valid port=%0d got=%b want=0", j, obs_rd_valid[j]);
      end
    end
  endtask

  task automatic test_alloc_basic();
    step(0, 2, 0, 0);
    total++;
    if (obs_ok !== 1'b1) begin bad++; $display("FAIL basic_alloc_ok got=%b want=1", obs_ok); end
    total++;
    if (bus.dispatch_ptr_o !== 6'd2 || bus.rrf_freenum_o !== 7'd62) begin
      bad++; $display("FAIL basic_state disp=%0d free=%0d want disp=2 free=62",
                      bus.dispatch_ptr_o, bus.rrf_freenum_o);
    end
  endtask

  task automatic test_fill();
    repeat (31) step(0, 2, 0, 0);
    total++;
    if (bus.rrf_freenum_o !== 7'd0 || bus.dispatch_ptr_o !== 6'd0) begin
      bad++; $display("FAIL fill_full free=%0d disp=%0d want free=0 disp=0",
                      bus.rrf_freenum_o, bus.dispatch_ptr_o);
    end
    step(0, 1, 0, 0);
    total++;
    if (obs_ok !== 1'b0) begin bad++; $display("FAIL full_reject got=%b want=0", obs_ok); end
    step(0, 0, 1, 0);
    total++;
    if (bus.rrf_freenum_o !== 7'd1) begin
      bad++; $display("FAIL retire_one free got=%0d want=1", bus.rrf_freenum_o);
    end
    step(0, 1, 0, 0);
    total++;
    if (obs_ok !== 1'b1) begin bad++; $display("FAIL last_grant got=%b want=1", obs_ok); end
  endtask

  task automatic test_writeback();
    g_rd_addr = '{6'd5, 6'd6, 6'd0, 6'd0};
    g_wb_en[0] = 1'b1; g_wb_addr[0] = 6'd5; g_wb_data[0] = 32'hDEADBEEF;
    step(0, 0, 0, 0);
    total++;
    if (obs_rd_data[0] !== 32'hDEADBEEF || obs_rd_valid[0] !== 1'b1) begin
      bad++; $display("FAIL wb_bypass got=%h/%b want=deadbeef/1", obs_rd_data[0], obs_rd_valid[0]);
    end
    step(0, 0, 0, 0);
    total++;
    if (obs_rd_data[0] !== 32'hDEADBEEF || obs_rd_valid[0] !== 1'b1) begin
      bad++; $display("FAIL wb_array got=%h/%b want=deadbeef/1", obs_rd_data[0], obs_rd_valid[0]);
    end
    total++;
    if (obs_rd_valid[1] !== 1'b0) begin
      bad++; $display("FAIL unwritten_valid got=%b want=0", obs_rd_valid[1]);
    end
    g_wb_en[0] = 1'b1; g_wb_addr[0] = 6'd5; g_wb_data[0] = 32'h11112222;
    g_wb_en[2] = 1'b1; g_wb_addr[2] = 6'd5; g_wb_data[2] = 32'h33334444;
    step(0, 0, 0, 0);
    total++;
    if (obs_rd_data[0] !== 32'h33334444) begin
      bad++; $display("FAIL wb_prio_bypass got=%h want=33334444", obs_rd_data[0]);
    end
    step(0, 0, 0, 0);
    total++;
    if (obs_rd_data[0] !== 32'h33334444) begin
      bad++; $display("FAIL wb_prio_array got=%h want=33334444", obs_rd_data[0]);
    end
    g_wb_en[0] = 1'b1; g_wb_addr[0] = 6'd1; g_wb_data[0] = 32'hA1A1A1A1;
    g_wb_en[1] = 1'b1; g_wb_addr[1] = 6'd2; g_wb_data[1] = 32'hB2B2B2B2;
    step(0, 0, 0, 0);
    g_wb_en[0] = 1'b1; g_wb_addr[0] = 6'd1; g_wb_data[0] = 32'hC3C3C3C3;
    step(0, 0, 0, 0);
    total++;
    if (obs_com1 !== 32'hA1A1A1A1 || obs_com2 !== 32'hB2B2B2B2) begin
      bad++; $display("FAIL com_nobypass got=%h,%h want=a1a1a1a1,b2b2b2b2", obs_com1, obs_com2);
    end
    step(0, 0, 0, 0);
    total++;
    if (obs_com1 !== 32'hC3C3C3C3) begin
      bad++; $display("FAIL com_update got=%h want=c3c3c3c3", obs_com1);
    end
  endtask

  task automatic test_mispredict();
    step(1, 0, 0, 0);
    repeat (10) step(0, 2, 0, 0);
    repeat (5) step(0, 0, 2, 0);
    total++;
    if (bus.commit_ptr_o !== 6'd10 || bus.dispatch_ptr_o !== 6'd20) begin
      bad++; $display("FAIL prmiss_setup com=%0d disp=%0d want com=10 disp=20",
                      bus.commit_ptr_o, bus.dispatch_ptr_o);
    end
    g_wb_en[1] = 1'b1; g_wb_addr[1] = 6'd15; g_wb_data[1] = 32'h0F0F0F0F;
    step(0, 2, 2, 1);
    total++;
    if (obs_ok !== 1'b0) begin bad++; $display("FAIL prmiss_alloc_ok got=%b want=0", obs_ok); end
    total++;
    if (bus.dispatch_ptr_o !== 6'd12 || bus.commit_ptr_o !== 6'd12 || bus.rrf_freenum_o !== 7'd64) begin
      bad++; $display("FAIL prmiss_state disp=%0d com=%0d free=%0d want 12/12/64",
                      bus.dispatch_ptr_o, bus.commit_ptr_o, bus.rrf_freenum_o);
    end
    g_rd_addr[2] = 6'd15;
    step(0, 0, 0, 0);
    total++;
    if (obs_rd_valid[2] !== 1'b1 || obs_rd_data[2] !== 32'h0F0F0F0F) begin
      bad++; $display("FAIL prmiss_wb got=%h/%b want=0f0f0f0f/1", obs_rd_data[2], obs_rd_valid[2]);
    end
  endtask

  task automatic test_concurrent();
    repeat (30) step(0, 2, 0, 0);
    step(0, 1, 0, 0);
    total++;
    if (bus.rrf_freenum_o !== 7'd3) begin
      bad++; $display("FAIL conc_setup free got=%0d want=3", bus.rrf_freenum_o);
    end
    step(0, 2, 2, 0);
    total++;
    if (bus.rrf_freenum_o !== 7'd3 || bus.dispatch_ptr_o !== 6'd11) begin
      bad++; $display("FAIL conc_alloc_retire free=%0d disp=%0d want free=3 disp=11",
                      bus.rrf_freenum_o, bus.dispatch_ptr_o);
    end
    g_rd_addr[0] = 6'd11;
    g_wb_en[0] = 1'b1; g_wb_addr[0] = 6'd11; g_wb_data[0] = 32'h5A5A5A5A;
    step(0, 1, 0, 0);
    total++;
    if (obs_ok !== 1'b1 || obs_rd_valid[0] !== 1'b1) begin
      bad++; $display("FAIL clr_vs_wb_cycle ok=%b valid=%b want 1/1", obs_ok, obs_rd_valid[0]);
    end
    step(0, 0, 0, 0);
    total++;
    if (obs_rd_valid[0] !== 1'b0) begin
      bad++; $display("FAIL clr_wins got=%b want=0", obs_rd_valid[0]);
    end
  endtask

  task automatic test_reset_mid();
    g_rd_addr = '{6'd5, 6'd15, 6'd11, 6'd20};
    g_wb_en[0] = 1'b1; g_wb_addr[0] = 6'd20; g_wb_data[0] = 32'h12345678;
    step(1, 2, 1, 0);
    total++;
    if (obs_ok !== 1'b0) begin bad++; $display("FAIL midreset_alloc_ok got=%b want=0", obs_ok); end
    total++;
    if (bus.dispatch_ptr_o !== 6'd0 || bus.commit_ptr_o !== 6'd0 || bus.rrf_freenum_o !== 7'd64) begin
      bad++; $display("FAIL midreset_state disp=%0d com=%0d free=%0d want 0/0/64",
                      bus.dispatch_ptr_o, bus.commit_ptr_o, bus.rrf_freenum_o);
    end
    step(0, 0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      total++;
      if (obs_rd_valid[j] !== 1'b0) begin
        bad++; $display("FAIL midreset_rd_valid port=%0d got=%b want=0", j, obs_rd_valid[j]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          req, com, occ;
    bit          pm;
    bit          ev[4];
    logic [31:0] ed[4];
    for (int c = 0; c < 400; c++) begin
      req = $urandom_range(0, 2);
      occ = N - m_free;
      com = $urandom_range(0, (occ < 2) ? occ : 2);
      pm  = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < 3; k++) begin
        g_wb_en[k]   = ($urandom_range(0, 2) == 0);
        g_wb_addr[k] = 6'($urandom_range(0, N - 1));
        g_wb_data[k] = $urandom;
      end
      for (int j = 0; j < 4; j++)
        g_rd_addr[j] = (j < 3 && $urandom_range(0, 1) == 1) ? g_wb_addr[j] : 6'($urandom_range(0, N - 1));
      for (int j = 0; j < 4; j++) begin
        ev[j] = m_valid[g_rd_addr[j]];
        ed[j] = m_data[g_rd_addr[j]];
        for (int k = 0; k < 3; k++) begin
          if (g_wb_en[k] && g_wb_addr[k] == g_rd_addr[j]) begin
            ev[j] = 1'b1;
            ed[j] = g_wb_data[k];
          end
        end
      end
      step(0, req, com, pm);
      for (int j = 0; j < 4; j++) begin
        total++;
        if (obs_rd_valid[j] !== ev[j] || (ev[j] && obs_rd_data[j] !== ed[j])) begin
          bad++; $display("FAIL rand_rd cyc=%0d port=%0d got=%h/%b want=%h/%b",
                          c, j, obs_rd_data[j], obs_rd_valid[j], ed[j], ev[j]);
        end
      end
    end
  endtask

  initial begin
    bus.req_num_i = 2'd0; bus.comnum_i = 2'd0; bus.prmiss_i = 1'b0;
    bus.wb1_en_i = 1'b0; bus.wb1_addr_i = '0; bus.wb1_data_i = '0;
    bus.wb2_en_i = 1'b0; bus.wb2_addr_i = '0; bus.wb2_data_i = '0;
    bus.wb3_en_i = 1'b0; bus.wb3_addr_i = '0; bus.wb3_data_i = '0;
    bus.rd1_addr_i = '0; bus.rd2_addr_i = '0; bus.rd3_addr_i = '0; bus.rd4_addr_i = '0;
    g_wb_en   = '{default: 1'b0};
    g_wb_addr = '{default: 6'd0};
    g_wb_data = '{default: 32'd0};
    g_rd_addr = '{default: 6'd0};
    foreach (m_valid[i]) m_valid[i] = 1'b0;

    test_reset();
    test_alloc_basic();
    test_fill();
    test_writeback();
    test_mispredict();
    test_concurrent();
    test_reset_mid();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
